// File: rtl/puf_challenge_scrambler_pkg.sv
// Shared definitions for the PUF challenge scrambler: FSM states, LFSR taps
// and the seed substituted for an all-zero seed.
package puf_challenge_scrambler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_EMIT,
        ST_DONE
    } scr_state_t;

    // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting Fibonacci register.
    localparam logic [7:0] LFSR_TAPS         = 8'hB8;
    localparam logic [7:0] DEFAULT_ZERO_SEED = 8'hA5;

endpackage

// File: rtl/puf_lfsr8.sv
// Combinational next-state function of the 8-bit challenge LFSR.
module puf_lfsr8
    import puf_challenge_scrambler_pkg::*;
(
    input  logic [7:0] s,
    output logic [7:0] s_next
);

    assign s_next = {s[6:0], ^(s & LFSR_TAPS)};

endmodule

// File: rtl/puf_challenge_scrambler.sv
// Expands an 8-bit seed into P_NUM_CHAL LFSR challenge words and hands them
// to the PUF array over valid/ready with sequential addresses.
module puf_challenge_scrambler
    import puf_challenge_scrambler_pkg::*;
#(
    parameter int unsigned P_ADDR_WIDTH = 12,
    parameter int unsigned P_DATA_WIDTH = 32,
    parameter int unsigned P_NUM_CHAL   = 16,
    parameter logic [7:0]  P_ZERO_SEED  = DEFAULT_ZERO_SEED
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    En_Scrambler,
    input  logic                    Reset_Scrambler,
    input  logic [7:0]              Seed_Data_LFSR,
    output logic                    done_Scrambler,
    output logic                    Chal_Valid,
    input  logic                    Chal_Ready,
    output logic [P_DATA_WIDTH-1:0] Chal_Data,
    output logic [P_ADDR_WIDTH-1:0] Chal_Addr
);

    localparam int unsigned BYTES = P_DATA_WIDTH / 8;
    localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0]          LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [P_ADDR_WIDTH-1:0] LAST_WORD = P_ADDR_WIDTH'(P_NUM_CHAL - 1);

    scr_state_t              state_q, state_d;
    logic [7:0]              lfsr_q, lfsr_d, lfsr_next;
    logic [BCW-1:0]          byte_q, byte_d;
    logic [P_ADDR_WIDTH-1:0] word_q, word_d;
    logic [P_DATA_WIDTH-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;

    puf_lfsr8 u_lfsr (
        .s      (lfsr_q),
        .s_next (lfsr_next)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            lfsr_q  <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        byte_d  = byte_q;
        word_d  = word_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = done_q;

        // A restart overrides every state, including a word mid-handshake.
        if (Reset_Scrambler) begin
            lfsr_d  = (Seed_Data_LFSR == '0) ? P_ZERO_SEED : Seed_Data_LFSR;
            byte_d  = '0;
            word_d  = '0;
            valid_d = 1'b0;
            done_d  = 1'b0;
            state_d = ST_GEN;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_GEN: begin
                    if (En_Scrambler) begin
                        lfsr_d = lfsr_next;
                        data_d = P_DATA_WIDTH'({data_q, lfsr_next});
                        if (byte_q == LAST_BYTE) begin
                            byte_d  = '0;
                            valid_d = 1'b1;
                            state_d = ST_EMIT;
                        end else begin
                            byte_d = byte_q + 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (Chal_Ready) begin
                        valid_d = 1'b0;
                        if (word_q == LAST_WORD) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            word_d  = word_q + 1'b1;
                            byte_d  = '0;
                            state_d = ST_GEN;
                        end
                    end
                end
                ST_DONE: done_d = 1'b1;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign done_Scrambler = done_q;
    assign Chal_Valid     = valid_q;
    assign Chal_Data      = data_q;
    assign Chal_Addr      = word_q;

endmodule

// File: tb/tb_puf_challenge_scrambler.sv
// Directed self-checking bench for puf_challenge_scrambler (default parameters).
module tb_puf_challenge_scrambler;

    logic        clk = 1'b0;
    logic        Reset;
    logic        En_Scrambler;
    logic        Reset_Scrambler;
    logic [7:0]  Seed_Data_LFSR;
    logic        done_Scrambler;
    logic        Chal_Valid;
    logic        Chal_Ready;
    logic [31:0] Chal_Data;
    logic [11:0] Chal_Addr;

    int checks   = 0;
    int failures = 0;
    int n;

    puf_challenge_scrambler #(
        .P_ADDR_WIDTH (12),
        .P_DATA_WIDTH (32),
        .P_NUM_CHAL   (16),
        .P_ZERO_SEED  (8'hA5)
    ) dut (
        .clk             (clk),
        .Reset           (Reset),
        .En_Scrambler    (En_Scrambler),
        .Reset_Scrambler (Reset_Scrambler),
        .Seed_Data_LFSR  (Seed_Data_LFSR),
        .done_Scrambler  (done_Scrambler),
        .Chal_Valid      (Chal_Valid),
        .Chal_Ready      (Chal_Ready),
        .Chal_Data       (Chal_Data),
        .Chal_Addr       (Chal_Addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a restart for one cycle; n counts edges from the load edge (=1).
    task automatic load(input logic [7:0] seed);
        Seed_Data_LFSR  = seed;
        Reset_Scrambler = 1'b1;
        tick();
        Reset_Scrambler = 1'b0;
        n = 1;
    endtask

    task automatic wait_valid();
        int lim;
        lim = n + 200;
        while (Chal_Valid !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done();
        int lim;
        lim = n + 300;
        while (done_Scrambler !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
    endtask

    initial begin
        Reset = 1'b1; En_Scrambler = 1'b0; Reset_Scrambler = 1'b0;
        Seed_Data_LFSR = 8'h00; Chal_Ready = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(Chal_Valid), 32'd0);
        chk("rst_done",  32'(done_Scrambler), 32'd0);
        chk("rst_data",  Chal_Data, 32'd0);
        chk("rst_addr",  32'(Chal_Addr), 32'd0);

        // IDLE holds even with enable and ready high.
        Reset = 1'b0; En_Scrambler = 1'b1; Chal_Ready = 1'b1;
        tick(); tick(); tick();
        chk("idle_valid", 32'(Chal_Valid), 32'd0);
        chk("idle_data",  Chal_Data, 32'd0);

        // Seed 01, ready tied high: words and latency.
        load(8'h01);
        wait_valid();
        chk("t1_first_valid_n", 32'(n), 32'd5);
        chk("t1_w0_data", Chal_Data, 32'h02040811);
        chk("t1_w0_addr", 32'(Chal_Addr), 32'd0);
        tick(); n++;
        chk("t1_valid_drop", 32'(Chal_Valid), 32'd0);
        wait_valid();
        chk("t1_w1_n", 32'(n), 32'd10);
        chk("t1_w1_data", Chal_Data, 32'h23478E1C);
        chk("t1_w1_addr", 32'(Chal_Addr), 32'd1);
        wait_done();
        chk("t1_done_n", 32'(n), 32'd81);
        chk("t1_done_valid", 32'(Chal_Valid), 32'd0);
        chk("t1_done_addr", 32'(Chal_Addr), 32'd15);
        tick(); tick(); tick();
        chk("t1_done_hold", 32'(done_Scrambler), 32'd1);
        chk("t1_done_novalid", 32'(Chal_Valid), 32'd0);
        chk("t1_done_addr_hold", 32'(Chal_Addr), 32'd15);

        // Reset while in DONE, then a fresh run.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("t6_done", 32'(done_Scrambler), 32'd0);
        chk("t6_valid", 32'(Chal_Valid), 32'd0);
        chk("t6_data", Chal_Data, 32'd0);
        chk("t6_addr", 32'(Chal_Addr), 32'd0);
        load(8'h01);
        wait_valid();
        chk("t6_w0_n", 32'(n), 32'd5);
        chk("t6_w0_data", Chal_Data, 32'h02040811);
        wait_done();
        chk("t6_done_n", 32'(n), 32'd81);

        // Zero seed substitutes A5: A5->4A->95->2A->54.
        load(8'h00);
        wait_valid();
        chk("t2_w0_data", Chal_Data, 32'h4A952A54);
        chk("t2_w0_msb", 32'(Chal_Data[31:24]), 32'h4A);

        // Backpressure for 7 cycles in EMIT.
        Chal_Ready = 1'b0;
        load(8'h01);
        wait_valid();
        chk("t3_w0_n", 32'(n), 32'd5);
        for (int i = 0; i < 7; i++) begin
            chk("t3_hold_valid", 32'(Chal_Valid), 32'd1);
            chk("t3_hold_data", Chal_Data, 32'h02040811);
            chk("t3_hold_addr", 32'(Chal_Addr), 32'd0);
            tick();
        end
        Chal_Ready = 1'b1;
        tick();
        Chal_Ready = 1'b0;
        chk("t3_hs_valid", 32'(Chal_Valid), 32'd0);
        n = 0;
        wait_valid();
        chk("t3_w1_n", 32'(n), 32'd4);
        chk("t3_w1_addr", 32'(Chal_Addr), 32'd1);
        chk("t3_w1_data", Chal_Data, 32'h23478E1C);
        Chal_Ready = 1'b1;

        // Enable dropped for 3 cycles after two steps.
        load(8'h01);
        tick(); tick(); n = n + 2;
        En_Scrambler = 1'b0;
        tick(); tick(); tick(); n = n + 3;
        chk("t4_frozen_valid", 32'(Chal_Valid), 32'd0);
        En_Scrambler = 1'b1;
        wait_valid();
        chk("t4_w0_n", 32'(n), 32'd8);
        chk("t4_w0_data", Chal_Data, 32'h02040811);
        wait_done();
        chk("t4_done_n", 32'(n), 32'd84);

        // Restart coincident with the word-5 handshake.
        load(8'h01);
        while (!(Chal_Valid === 1'b1 && Chal_Addr == 12'd5) && n < 200) begin
            tick();
            n++;
        end
        chk("t5_w5_n", 32'(n), 32'd30);
        Seed_Data_LFSR  = 8'h01;
        Reset_Scrambler = 1'b1;
        tick();
        Reset_Scrambler = 1'b0;
        n = 1;
        chk("t5_valid", 32'(Chal_Valid), 32'd0);
        chk("t5_addr", 32'(Chal_Addr), 32'd0);
        chk("t5_done", 32'(done_Scrambler), 32'd0);
        wait_valid();
        chk("t5_w0_n", 32'(n), 32'd5);
        chk("t5_w0_data", Chal_Data, 32'h02040811);
        chk("t5_w0_addr", 32'(Chal_Addr), 32'd0);

        // Reset mid-run: back to IDLE with no done pulse.
        tick(); tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("mid_rst_done", 32'(done_Scrambler), 32'd0);
            chk("mid_rst_valid", 32'(Chal_Valid), 32'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/puf_challenge_scrambler.md
Name: puf_challenge_scrambler

Overview:
LFSR challenge scrambler, the responder to the PUF controller's scrambler handshake (En_Scrambler / Reset_Scrambler / Seed_Data_LFSR / done_Scrambler).
- From an 8-bit seed it expands a deterministic stream of P_NUM_CHAL challenge words.
- Each word goes to the PUF array over a valid/ready handshake, with a sequential address.
- It signals completion back to the controller.

Parameters:
P_ADDR_WIDTH, 12, width of Chal_Addr; P_NUM_CHAL <= 2**P_ADDR_WIDTH.
P_DATA_WIDTH, 32, challenge word width; must be a multiple of 8.
P_NUM_CHAL, 16, challenge words per run; must be >= 1.
P_ZERO_SEED, 8'hA5, substitute seed used when the supplied seed is 0.

Ports:
clk  in  1  clock, rising edge.
Reset  in  1  synchronous, active-high block reset.
En_Scrambler  in  1  run enable from controller; low pauses generation.
Reset_Scrambler  in  1  synchronous run restart; loads the seed.
Seed_Data_LFSR  in  8  seed, sampled only when Reset_Scrambler=1.
done_Scrambler  out  1  run complete, level.
Chal_Valid  out  1  Chal_Data/Chal_Addr valid.
Chal_Ready  in  1  PUF array accepts the word.
Chal_Data  out  P_DATA_WIDTH  challenge word.
Chal_Addr  out  P_ADDR_WIDTH  word index, 0..P_NUM_CHAL-1.

Behaviour:
- One clock (clk); reset is synchronous and active-high (Reset). All state updates on the rising edge of clk.
- Reset=1: state IDLE, lfsr=8'h00, byte counter=0, word counter=0, Chal_Data=0, Chal_Addr=0, Chal_Valid=0, done_Scrambler=0.
- Priority, highest first: Reset, then Reset_Scrambler, then En_Scrambler.
- LFSR step (Fibonacci, x^8+x^6+x^5+x^4+1):
  - fb = s[7]^s[5]^s[4]^s[3]
  - s_next = {s[6:0], fb}
- Word assembly: BYTES = P_DATA_WIDTH/8. Each GEN cycle performs one LFSR step and shifts s_next into Chal_Data from the LSB end (Chal_Data <= {Chal_Data[P_DATA_WIDTH-9:0], s_next}). The first byte therefore ends up in the MSBs.
- States:
  - IDLE: outputs held. Reset_Scrambler=1 -> LOAD action.
  - LOAD action, taken in any state whenever Reset_Scrambler=1:
    - lfsr <= (Seed_Data_LFSR==0) ? P_ZERO_SEED : Seed_Data_LFSR
    - byte counter=0, word counter=0, Chal_Addr=0, Chal_Valid=0, done_Scrambler=0
    - next state GEN
    - This applies regardless of En_Scrambler, and aborts any word in flight.
  - GEN: with En_Scrambler=1, one step per cycle. After the BYTES-th step: Chal_Valid<=1 and go to EMIT. With En_Scrambler=0, everything is frozen.
  - EMIT: Chal_Valid=1; Chal_Data and Chal_Addr are held stable until Chal_Valid&&Chal_Ready.
    - A handshake completes even if En_Scrambler=0.
    - On handshake, Chal_Valid<=0.
    - If word counter==P_NUM_CHAL-1: go to DONE.
    - Otherwise: word counter++, Chal_Addr++, byte counter=0, go to GEN.
  - DONE: done_Scrambler=1, held until Reset_Scrambler or Reset. En_Scrambler is ignored; the LFSR does not advance.
- Latency with Chal_Ready tied to 1 and En_Scrambler held at 1:
  - The first Chal_Valid rises BYTES cycles after the LOAD cycle.
  - Each word occupies BYTES+1 cycles.
  - done_Scrambler rises in the cycle after the last handshake.
- Boundary conditions:
  - Chal_Ready=1 while Chal_Valid=0: ignored.
  - Seed 0: P_ZERO_SEED is substituted, so the LFSR never locks up.
  - The address never wraps within a run.
  - Reset_Scrambler in the same cycle as a handshake: LOAD wins and the handshake is not counted.
  - Reset mid-run returns to IDLE with no done_Scrambler pulse.

Decomposition:
- Shared package: the state encodings (IDLE, GEN, EMIT, DONE), the LFSR tap constant 8'hB8, and the default zero-seed constant.
- Sub-module: puf_lfsr8, a combinational next-state function (s -> s_next), reused by the verification model.

Test Plan:
1. Seed 8'h01, P_DATA_WIDTH=32, Ready=1 -> word0 = 32'h02040811 @ addr 0, word1 = 32'h23478E1C @ addr 1; done_Scrambler rises 16*5+1 cycles after LOAD.
2. Seed 8'h00 -> first step from 8'hA5 gives 8'h4A, so word0[31:24] = 8'h4A.
3. Hold Chal_Ready=0 for 7 cycles while in EMIT -> Chal_Valid, Chal_Data and Chal_Addr are stable all 7 cycles; exactly one handshake is counted when Ready rises.
4. Drop En_Scrambler for 3 cycles mid-GEN -> the word value is unchanged versus the uninterrupted run, and completion is delayed by exactly 3 cycles.
5. Assert Reset_Scrambler with seed 8'h01 during word 5 -> Chal_Valid=0 next cycle, the stream restarts at addr 0 with 32'h02040811, and done_Scrambler stays 0.
6. Assert Reset in DONE -> all outputs 0 next cycle; Reset_Scrambler+En then produces a full fresh run.
